// File: rtl/mmacc_row_accumulator_if.sv
// mmacc_row_accumulator_if
//   Bundles the two handshakes of the row accumulator.
//   Input side : in_valid/in_ready/in_last/in_row   (partial rows from the datapath)
//   Output side: out_valid/out_ready/out_row/out_chunks/out_forced (finished rows to writeback)
//   modport slave  : view taken by the accumulator
//   modport master : view taken by whoever drives partial rows and consumes results
interface mmacc_row_accumulator_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int ACC_WIDTH   = 72,
  parameter int CNT_WIDTH   = 5
);
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [DATA_WIDTH*2-1:0]   in_row [0:CHUNK_WIDTH-1];
  logic                      out_valid;
  logic                      out_ready;
  logic [ACC_WIDTH-1:0]      out_row [0:CHUNK_WIDTH-1];
  logic [CNT_WIDTH-1:0]      out_chunks;
  logic                      out_forced;

  modport slave (
    input  in_valid, in_last, in_row, out_ready,
    output in_ready, out_valid, out_row, out_chunks, out_forced
  );

  modport master (
    output in_valid, in_last, in_row, out_ready,
    input  in_ready, out_valid, out_row, out_chunks, out_forced
  );
endinterface

// File: rtl/mmacc_row_accumulator.sv
// mmacc_row_accumulator
//   Accumulates successive K-chunk partial rows element-wise and presents the
//   finished row on a valid/ready interface. A row completes on in_last or when
//   MAX_CHUNKS chunks have been absorbed (forced flush).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset (highest priority)
//   clear  : synchronous abort, drops any partial or pending row
//   bus    : slave side of mmacc_row_accumulator_if (input and output handshakes)
module mmacc_row_accumulator #(
  parameter int DATA_WIDTH  = 32,
  parameter int CHUNK_WIDTH = 8,
  parameter int ACC_WIDTH   = 72,
  parameter int MAX_CHUNKS  = 16,
  parameter int CNT_WIDTH   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  mmacc_row_accumulator_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  state_t                 state_reg, state_next;
  logic [ACC_WIDTH-1:0]   acc_reg [0:CHUNK_WIDTH-1];
  logic [ACC_WIDTH-1:0]   acc_next [0:CHUNK_WIDTH-1];
  logic [ACC_WIDTH-1:0]   sum [0:CHUNK_WIDTH-1];
  logic [CNT_WIDTH-1:0]   count_reg, count_next, count_inc;
  logic [ACC_WIDTH-1:0]   out_row_reg [0:CHUNK_WIDTH-1];
  logic [ACC_WIDTH-1:0]   out_row_next [0:CHUNK_WIDTH-1];
  logic [CNT_WIDTH-1:0]   out_chunks_reg, out_chunks_next;
  logic                   out_forced_reg, out_forced_next;
  logic                   in_ready;
  logic                   accept;

  assign in_ready = rst_n & ~clear & (state_reg != OUTPUT);
  assign accept   = bus.in_valid & in_ready;

  // Accumulators are always zero in IDLE, so the same adder serves both the
  // first chunk (acc = in_row) and later chunks (acc += in_row).
  assign count_inc = count_reg + CNT_WIDTH'(1);

  genvar gi;
  generate
    for (gi = 0; gi < CHUNK_WIDTH; gi++) begin : g_elem
      assign sum[gi]         = acc_reg[gi] + ACC_WIDTH'(bus.in_row[gi]);
      assign bus.out_row[gi] = out_row_reg[gi];
    end
  endgenerate

  assign bus.in_ready   = in_ready;
  assign bus.out_valid  = (state_reg == OUTPUT);
  assign bus.out_chunks = out_chunks_reg;
  assign bus.out_forced = out_forced_reg;

  always_comb begin
    state_next      = state_reg;
    acc_next        = acc_reg;
    count_next      = count_reg;
    out_row_next    = out_row_reg;
    out_chunks_next = out_chunks_reg;
    out_forced_next = out_forced_reg;

    case (state_reg)
      IDLE, ACCUM: begin
        if (accept) begin
          acc_next   = sum;
          count_next = count_inc;
          if (bus.in_last || (count_inc == CNT_WIDTH'(MAX_CHUNKS))) begin
            state_next      = OUTPUT;
            out_row_next    = sum;
            out_chunks_next = count_inc;
            // Forced only when the chunk limit, not in_last, closed the row.
            out_forced_next = ~bus.in_last;
          end else begin
            state_next = ACCUM;
          end
        end
      end
      OUTPUT: begin
        if (bus.out_ready) begin
          state_next      = IDLE;
          count_next      = '0;
          out_chunks_next = '0;
          out_forced_next = 1'b0;
          for (int i = 0; i < CHUNK_WIDTH; i++) begin
            acc_next[i]     = '0;
            out_row_next[i] = '0;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    // Abort wins over everything except reset, including an output handshake.
    if (clear) begin
      state_next      = IDLE;
      count_next      = '0;
      out_chunks_next = '0;
      out_forced_next = 1'b0;
      for (int i = 0; i < CHUNK_WIDTH; i++) begin
        acc_next[i]     = '0;
        out_row_next[i] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      count_reg      <= '0;
      out_chunks_reg <= '0;
      out_forced_reg <= 1'b0;
      for (int i = 0; i < CHUNK_WIDTH; i++) begin
        acc_reg[i]     <= '0;
        out_row_reg[i] <= '0;
      end
    end else begin
      state_reg      <= state_next;
      count_reg      <= count_next;
      out_chunks_reg <= out_chunks_next;
      out_forced_reg <= out_forced_next;
      for (int i = 0; i < CHUNK_WIDTH; i++) begin
        acc_reg[i]     <= acc_next[i];
        out_row_reg[i] <= out_row_next[i];
      end
    end
  end

endmodule

// File: doc/mmacc_row_accumulator.md
Name: mmacc_row_accumulator

Overview:
- Sequential stage directly downstream of the combinational matmul row datapath.
- Consumes one CHUNK_WIDTH-wide partial output row per K-chunk and accumulates successive chunks element-wise.
- Presents the finished output row on a valid/ready interface to the writeback stage.
- Allows a full dot product over K = n*CHUNK_HEIGHT to be built from repeated single-chunk datapath evaluations.

Parameters:
- DATA_WIDTH, 32: operand width of the upstream datapath. Each partial element is DATA_WIDTH*2 bits.
- CHUNK_WIDTH, 8: number of elements per row.
- ACC_WIDTH, 72: width of each accumulator and result element. Must be ≥ DATA_WIDTH*2.
- MAX_CHUNKS, 16: maximum number of K-chunks per row before a forced flush.
- CNT_WIDTH, 5: width of the chunk counter. Must satisfy 2^CNT_WIDTH > MAX_CHUNKS.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- clear  in  1  synchronous abort; drops any partial or pending row.
- in_valid  in  1  partial row present.
- in_ready  out  1  stage accepts a partial row this cycle.
- in_last  in  1  this partial row is the final K-chunk of the output row.
- in_row  in  [DATA_WIDTH*2-1:0] x [0:CHUNK_WIDTH-1]  partial row from the datapath.
- out_valid  out  1  result row valid.
- out_ready  in  1  downstream accepts the result.
- out_row  out  [ACC_WIDTH-1:0] x [0:CHUNK_WIDTH-1]  accumulated row.
- out_chunks  out  CNT_WIDTH  number of chunks summed into out_row.
- out_forced  out  1  row was flushed at MAX_CHUNKS without in_last.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=IDLE; all accumulators 0; count 0.
  - out_valid=0, out_row all 0, out_chunks=0, out_forced=0.
  - in_ready=0 during the reset cycle.
- States:
  - IDLE: no partial sum.
  - ACCUM: at least one chunk absorbed.
  - OUTPUT: result held.
- in_ready = rst_n & ~clear & (state != OUTPUT). A beat is accepted when in_valid & in_ready.
- Accept in IDLE:
  - acc[i] = zero-extend(in_row[i]); count = 1.
  - Go to ACCUM, or to OUTPUT if in_last.
- Accept in ACCUM:
  - acc[i] = acc[i] + zero-extend(in_row[i]), unsigned, modulo 2^ACC_WIDTH (wraps, no saturation); count += 1.
  - Go to OUTPUT if in_last or the new count == MAX_CHUNKS. Otherwise stay in ACCUM.
- Entering OUTPUT:
  - out_row is registered from the new acc; out_chunks = new count; out_valid=1.
  - out_forced=1 only when the transition was caused by reaching MAX_CHUNKS with in_last=0.
  - Latency: out_valid asserts on the cycle after the accepting edge of the last chunk.
- In OUTPUT:
  - out_row, out_chunks and out_forced are held stable while out_valid & ~out_ready.
  - On out_valid & out_ready: out_valid=0, accumulators and count cleared, go to IDLE.
  - in_ready is 0 throughout OUTPUT, so no bypass. The earliest next accept is the cycle after the handshake.
- No valid beats in ACCUM: state, accumulators and count are held indefinitely.
- clear=1 (any state):
  - Next state IDLE; accumulators and count cleared; out_valid=0; out_forced=0.
  - A concurrent in_valid beat is not accepted.
  - clear overrides a simultaneous out handshake (the row is dropped).
- rst_n=0 has priority over clear and over all handshakes. Reset mid-row discards the row.
- in_last on the first chunk of a row gives a single-chunk row: out_chunks=1.
- MAX_CHUNKS=1: every row completes after one chunk, with out_forced = ~in_last.
- out_row and out_chunks are 0 whenever out_valid=0, except while held in OUTPUT.

Test Plan:
- Single chunk: reset, in_row[i]=i+1 with in_last=1 → next cycle out_valid=1, out_row[i]=i+1, out_chunks=1, out_forced=0; hold out_ready=1 → IDLE.
- Three-chunk row, in_row[i]=100 on every beat with in_valid gaps, last=1 on the 3rd → out_row[i]=300, out_chunks=3.
- Backpressure: out_ready=0 for 5 cycles with in_valid=1 held → in_ready=0 throughout and out_row stable; out_ready=1 → handshake, then the next row accepted one cycle later.
- Forced flush: MAX_CHUNKS=16 with 16 beats and in_last=0 → out_chunks=16, out_forced=1; a 17th beat is only accepted after the output handshake.
- Wrap: ACC_WIDTH=64, two beats of 64'hFFFF_FFFF_FFFF_FFFF → out_row[i]=64'hFFFF_FFFF_FFFF_FFFE.
- Abort and reset:
  - clear after 2 chunks, with in_valid=1 in the same cycle → beat dropped; a following single-chunk row yields only its own data.
  - rst_n=0 in OUTPUT → out_valid=0 and out_row=0 next cycle.
